// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkg
// Purpose  : State indices, state encoding and config-bus defaults shared
//            with the read engine.
// Revision : 1.0
// ============================================================================
package axis_pkg;

  // One-hot bit positions of the scheduler state register
  localparam int ST_IDLE     = 0;
  localparam int ST_CFG_ID   = 1;
  localparam int ST_CFG_ADDR = 2;
  localparam int ST_CFG_LEN  = 3;
  localparam int ST_RUN      = 4;
  localparam int ST_DONE     = 5;
  localparam int ST_COUNT    = 6;

  // Config-bus register map of the read engine
  localparam int CFG_ID_DEFAULT        = 1;
  localparam int CFG_SEL_ADDR_DEFAULT  = 23;
  localparam int CFG_DATA_ADDR_DEFAULT = 24;

  typedef enum logic [ST_COUNT-1:0] {
    S_IDLE     = ST_COUNT'(1) << ST_IDLE,
    S_CFG_ID   = ST_COUNT'(1) << ST_CFG_ID,
    S_CFG_ADDR = ST_COUNT'(1) << ST_CFG_ADDR,
    S_CFG_LEN  = ST_COUNT'(1) << ST_CFG_LEN,
    S_RUN      = ST_COUNT'(1) << ST_RUN,
    S_DONE     = ST_COUNT'(1) << ST_DONE
  } sched_state_t;

  // Stream beats belong to the active descriptor from CFG_ID through RUN
  function automatic logic counts_beats(input sched_state_t s);
    return s[ST_CFG_ID] | s[ST_CFG_ADDR] | s[ST_CFG_LEN] | s[ST_RUN];
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_read_sched.sv
`default_nettype none
// ============================================================================
// Module   : axis_read_sched
// Purpose  : Accepts read descriptors, programs the read engine over the config
//            bus and tracks stream beats until the descriptor length is reached.
//            Optional watchdog: define AXIS_READ_SCHED_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module axis_read_sched
  import axis_pkg::*;
#(
  parameter int CONFIG_ID      = CFG_ID_DEFAULT,
  parameter int CONFIG_ADDR    = CFG_SEL_ADDR_DEFAULT,
  parameter int CONFIG_DATA    = CFG_DATA_ADDR_DEFAULT,
  parameter int CONFIG_AWIDTH  = 5,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CONFIG_DWIDTH-1:0] desc_addr,
  input  logic [CONFIG_DWIDTH-1:0] desc_len,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  output logic [CONFIG_AWIDTH-1:0] cfg_addr,
  output logic [CONFIG_DWIDTH-1:0] cfg_data,
  output logic                     cfg_valid,
  input  logic                     str_valid,
  input  logic                     str_ready,
  output logic                     busy,
`ifdef AXIS_READ_SCHED_TIMEOUT_EN
  output logic                     err,
`endif
  output logic                     done
);

  sched_state_t             r_state;
  logic [CONFIG_DWIDTH-1:0] r_addr;
  logic [CONFIG_DWIDTH-1:0] r_len;
  logic [CONFIG_DWIDTH-1:0] r_count;
  logic [CONFIG_DWIDTH:0]   w_count_inc;
  logic                     w_beat;
  logic                     w_accept;
  logic                     w_reached;
  logic                     w_timeout;

  assign w_beat      = str_valid & str_ready;
  assign w_accept    = desc_valid & desc_ready;
  // One extra bit keeps the compare exact at desc_len = all-ones
  assign w_count_inc = {1'b0, r_count} + (CONFIG_DWIDTH + 1)'(1);
  assign w_reached   = (r_count >= r_len) ||
                       (w_beat && (w_count_inc == {1'b0, r_len}));

`ifdef AXIS_READ_SCHED_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W:0]   w_idle_inc;

  assign w_idle_inc = {1'b0, r_idle} + (IDLE_W + 1)'(1);
  assign w_timeout  = (r_state == S_RUN) && !w_beat &&
                      (w_idle_inc == (IDLE_W + 1)'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
      err    <= 1'b0;
    end else begin
      if (r_state != S_RUN || w_beat) begin
        r_idle <= '0;
      end else begin
        r_idle <= w_idle_inc[IDLE_W-1:0];
      end
      if (w_timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_count    <= '0;
      desc_ready <= 1'b0;
      cfg_valid  <= 1'b0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done      <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;

      if (counts_beats(r_state) && w_beat && !w_count_inc[CONFIG_DWIDTH]) begin
        r_count <= w_count_inc[CONFIG_DWIDTH-1:0];
      end

      case (r_state)
        S_IDLE: begin
          desc_ready <= 1'b1;
          if (w_accept) begin
            r_addr     <= desc_addr;
            r_len      <= desc_len;
            r_count    <= '0;
            desc_ready <= 1'b0;
            busy       <= 1'b1;
            if (desc_len == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state   <= S_CFG_ID;
              cfg_valid <= 1'b1;
              cfg_addr  <= CONFIG_AWIDTH'(CONFIG_ADDR);
              cfg_data  <= CONFIG_DWIDTH'(CONFIG_ID);
            end
          end
        end
        S_CFG_ID: begin
          r_state   <= S_CFG_ADDR;
          cfg_valid <= 1'b1;
          cfg_addr  <= CONFIG_AWIDTH'(CONFIG_DATA);
          cfg_data  <= r_addr;
        end
        S_CFG_ADDR: begin
          r_state   <= S_CFG_LEN;
          cfg_valid <= 1'b1;
          cfg_addr  <= CONFIG_AWIDTH'(CONFIG_DATA);
          cfg_data  <= r_len;
        end
        S_CFG_LEN: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_reached || w_timeout) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          busy       <= 1'b0;
          desc_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          busy       <= 1'b0;
          desc_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_read_sched.sv
`default_nettype none
// Bench for axis_read_sched: table-driven descriptors, a reset-abort sequence
// and randomized descriptors checked cycle by cycle against a transaction model.
module tb_axis_read_sched;

  localparam int DW        = 32;
  localparam int TMO       = 64;
  localparam int MAX_EDGES = 3000;
  localparam int NO_LIMIT  = 1 << 30;
`ifdef AXIS_READ_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] desc_addr;
  logic [DW-1:0] desc_len;
  logic          desc_valid;
  logic          desc_ready;
  logic [4:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          str_valid;
  logic          str_ready;
  logic          busy;
  logic          done;
`ifdef AXIS_READ_SCHED_TIMEOUT_EN
  logic          err;
`endif

  axis_read_sched #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .desc_addr (desc_addr),
    .desc_len  (desc_len),
    .desc_valid(desc_valid),
    .desc_ready(desc_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .str_valid (str_valid),
    .str_ready (str_ready),
    .busy      (busy),
`ifdef AXIS_READ_SCHED_TIMEOUT_EN
    .err       (err),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] len;
    int            pct;        // str_ready probability in percent
    int            max_beats;  // handshakes offered after acceptance
    bit            queued;     // issued straight after the previous done
    int            exp_done;   // edge index of done after acceptance, -1 = model only
  } vec_t;

  int checks = 0;
  int errors = 0;
  int last_accept = 0;
  int last_done = 0;
  int obs_done = -1;
  bit err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_err(input string name);
`ifdef AXIS_READ_SCHED_TIMEOUT_EN
    chk(name, 32'(err), 32'(err_exp));
`endif
  endtask

  function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] l,
                              input int pct, input int mb, input bit q, input int ed);
    vec_t v;
    v.addr = a; v.len = l; v.pct = pct; v.max_beats = mb; v.queued = q; v.exp_done = ed;
    return v;
  endfunction

  task automatic drive_str(input int pct, input bit allow);
    str_ready = ($urandom_range(99) < 32'(pct));
    str_valid = allow && (pct >= 100 || $urandom_range(99) < 75);
  endtask

  // Edge 0 is the acceptance edge. Config words follow on cycles after edges
  // 0..2; beats on edges 1.. count; done follows the first edge >= 4 at which
  // the running beat total reaches the length (or the watchdog expires).
  task automatic run_desc(input vec_t v, input int id);
    int k, cum, issued, last_b, d, waits, acc;
    bit b;
    logic exp_v;
    logic [4:0] exp_a;
    logic [DW-1:0] exp_d;
    cum = 0; issued = 0; last_b = 0; d = -1; waits = 0; b = 1'b0; obs_done = -1;
    desc_addr = v.addr; desc_len = v.len; desc_valid = 1'b1;
    drive_str(v.pct, 1'b1);
    while (desc_ready !== 1'b1 && waits < 20) begin
      @(posedge clk); @(negedge clk);
      waits++;
      drive_str(v.pct, 1'b1);
    end
    if (desc_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept[%0d]: desc_ready=%b, required 1", id, desc_ready);
      desc_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (v.queued) chk($sformatf("accept_gap[%0d]", id), 32'(acc - last_accept), 32'(last_done + 2));
    @(posedge clk); @(negedge clk);
    desc_valid = 1'b0;
    k = 0;
    forever begin
      if (k > 0) begin
        if (b) begin cum++; last_b = k; end
      end
      if (d < 0) begin
        if (v.len == 0) d = 0;
        else if (k >= 4 && 32'(cum) >= v.len) d = k;
        else if (TMO_EN && k >= 4 && k - ((last_b > 3) ? last_b : 3) == TMO) begin
          d = k;
          err_exp = 1'b1;
        end
      end
      exp_v = (v.len != 0) && (k <= 2);
      exp_a = !exp_v ? 5'd0 : (k == 0) ? 5'd23 : 5'd24;
      exp_d = !exp_v ? '0 : (k == 0) ? 32'd1 : (k == 1) ? v.addr : v.len;
      chk($sformatf("cfg_valid[%0d] k=%0d", id, k), 32'(cfg_valid), 32'(exp_v));
      chk($sformatf("cfg_addr[%0d] k=%0d", id, k), 32'(cfg_addr), 32'(exp_a));
      chk($sformatf("cfg_data[%0d] k=%0d", id, k), cfg_data, exp_d);
      chk($sformatf("done[%0d] k=%0d", id, k), 32'(done), 32'(k == d));
      chk($sformatf("busy[%0d] k=%0d", id, k), 32'(busy), 32'd1);
      chk($sformatf("desc_ready[%0d] k=%0d", id, k), 32'(desc_ready), 32'd0);
      chk_err($sformatf("err[%0d] k=%0d", id, k));
      if (done === 1'b1 && obs_done < 0) obs_done = k;
      if (k == d) break;
      if (k >= MAX_EDGES) begin
        checks++; errors++;
        $display("FAIL done_bound[%0d]: no done after %0d edges, required by edge %0d", id, k, d);
        break;
      end
      drive_str(v.pct, issued < v.max_beats);
      b = str_valid & str_ready;
      if (b) issued++;
      @(posedge clk); @(negedge clk);
      k++;
    end
    last_accept = acc;
    last_done = (d < 0) ? k : d;
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_len = '0;
    str_valid = 1'b0; str_ready = 1'b0;

    @(negedge clk);
    chk("reset desc_ready", 32'(desc_ready), 32'd0);
    chk("reset cfg_valid", 32'(cfg_valid), 32'd0);
    chk("reset cfg_addr", 32'(cfg_addr), 32'd0);
    chk("reset cfg_data", cfg_data, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk_err("reset err");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_reset desc_ready", 32'(desc_ready), 32'd1);
    chk("post_reset busy", 32'(busy), 32'd0);

    vecs.push_back(mk(32'h1000_0000, 32'd16, 100, NO_LIMIT, 1'b0, 16));
    vecs.push_back(mk(32'hDEAD_BEEF, 32'd0,  100, NO_LIMIT, 1'b1, 0));
    vecs.push_back(mk(32'h0000_0004, 32'd1,  100, NO_LIMIT, 1'b1, 4));
    vecs.push_back(mk(32'h2000_0000, 32'd4,  100, NO_LIMIT, 1'b1, 4));
    vecs.push_back(mk(32'h3000_0000, 32'd8,  100, NO_LIMIT, 1'b1, 8));
    vecs.push_back(mk(32'h4000_0040, 32'd32, 50,  NO_LIMIT, 1'b1, -1));
    vecs.push_back(mk(32'h5000_0000, 32'd2,  100, NO_LIMIT, 1'b1, 4));
`ifdef AXIS_READ_SCHED_TIMEOUT_EN
    vecs.push_back(mk(32'h6000_0000, 32'd8,  100, 3,        1'b1, 3 + TMO));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_desc(vecs[i], i);
      if (vecs[i].exp_done >= 0)
        chk($sformatf("done_edge[%0d]", i), 32'(obs_done), 32'(vecs[i].exp_done));
    end

    // Abort a descriptor with reset while it is writing CFG_ADDR
    desc_addr = 32'hA5A5_0000; desc_len = 32'd10; desc_valid = 1'b1;
    str_valid = 1'b0; str_ready = 1'b0;
    for (int w = 0; w < 20 && desc_ready !== 1'b1; w++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("abort accept desc_ready", 32'(desc_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    desc_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort pre cfg_valid", 32'(cfg_valid), 32'd1);
    chk("abort pre cfg_data", cfg_data, 32'hA5A5_0000);
    #2 rst = 1'b0;
    #1;
    chk("abort cfg_valid", 32'(cfg_valid), 32'd0);
    chk("abort cfg_addr", 32'(cfg_addr), 32'd0);
    chk("abort cfg_data", cfg_data, 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort desc_ready", 32'(desc_ready), 32'd0);
    err_exp = 1'b0;
    chk_err("abort err");
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("abort hold done", 32'(done), 32'd0);
      chk("abort hold desc_ready", 32'(desc_ready), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort release desc_ready", 32'(desc_ready), 32'd1);
    chk("abort release done", 32'(done), 32'd0);
    v = mk(32'h0BAD_F00D, 32'd5, 100, NO_LIMIT, 1'b0, 5);
    run_desc(v, 100);
    chk("after_abort done_edge", 32'(obs_done), 32'd5);

    for (int i = 0; i < 25; i++) begin
      int pct;
      case ($urandom_range(2))
        0:       pct = 100;
        1:       pct = 60;
        default: pct = 30;
      endcase
      v = mk($urandom, 32'($urandom_range(40)), pct, NO_LIMIT, 1'b1, -1);
      run_desc(v, 200 + i);
    end

    @(posedge clk); @(negedge clk);
    chk("final busy", 32'(busy), 32'd0);
    chk("final desc_ready", 32'(desc_ready), 32'd1);
    chk("final done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
